// File: rtl/mem_port_arbiter.sv
// Multi-channel front end that serialises 1/2/4-byte requests onto the byte-wide RAM/IO bus.
// Optional round-robin arbitration is enabled by defining MEM_PORT_ARB_RR_EN.
//
// Handshake: req_valid[i] with req_wr/req_size/req_addr/req_wdata stays stable until
// resp_ready[i] pulses for one cycle; resp_data is valid in that pulse cycle for reads.
module mem_port_arbiter #(
    parameter int                NUM_CH     = 2,
    parameter logic [NUM_CH-1:0] CLEAR_MASK = 2'b11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    input  logic [NUM_CH-1:0]      req_valid,
    input  logic [NUM_CH-1:0]      req_wr,
    input  logic [2*NUM_CH-1:0]    req_size,
    input  logic [32*NUM_CH-1:0]   req_addr,
    input  logic [32*NUM_CH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]      resp_ready,
    output logic [31:0]            resp_data,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [31:0]            mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [CW-1:0]     owner_q, owner_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       mem_a_q, mem_a_d;
    logic [7:0]        dout_q, dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [NUM_CH-1:0] resp_q, resp_d;
    logic              resp_rd_q, resp_rd_d;

    logic              grant;
    logic [CW-1:0]     grant_ch;
    logic              g_wr;
    logic [1:0]        g_size;
    logic [31:0]       g_addr;
    logic [31:0]       g_wdata;
    logic [2:0]        next_k;
    logic [31:0]       next_a;
    logic [1:0]        rd_k;

`ifdef MEM_PORT_ARB_RR_EN
    logic [CW-1:0]     ptr_q, ptr_d;
`endif

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    // Request selection; the FSM decides whether the grant is actually taken.
    always_comb begin
        int j;
        grant    = 1'b0;
        grant_ch = '0;
        g_wr     = 1'b0;
        g_size   = 2'd0;
        g_addr   = '0;
        g_wdata  = '0;
        j        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef MEM_PORT_ARB_RR_EN
            j = (int'(ptr_q) + i) % NUM_CH;
`else
            j = i;
`endif
            if (!grant && req_valid[j]) begin
                grant    = 1'b1;
                grant_ch = CW'(j);
                g_wr     = req_wr[j];
                g_size   = req_size[2*j +: 2];
                g_addr   = req_addr[32*j +: 32];
                g_wdata  = req_wdata[32*j +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nbytes_d  = nbytes_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        mem_a_d   = mem_a_q;
        dout_d    = dout_q;
        mem_wr_d  = 1'b0;
        resp_d    = '0;
        resp_rd_d = resp_rd_q;
`ifdef MEM_PORT_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        next_k    = cnt_q + 3'd1;
        next_a    = addr_q + {29'd0, next_k};
        rd_k      = 2'(cnt_q - 3'd1);

        case (state_q)
            IDLE: begin
                if (grant && !clear) begin
                    owner_d  = grant_ch;
                    addr_d   = g_addr;
                    wdata_d  = g_wdata;
                    cnt_d    = 3'd0;
                    nbytes_d = (g_size == 2'd0) ? 3'd1 : (g_size == 2'd1) ? 3'd2 : 3'd4;
                    mem_a_d  = g_addr;
`ifdef MEM_PORT_ARB_RR_EN
                    ptr_d    = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
`endif
                    if (g_wr) begin
                        if (is_io(g_addr) && io_buffer_full) begin
                            state_d = IO_WAIT;
                            mem_a_d = '0;
                        end else begin
                            state_d  = WRITE;
                            dout_d   = g_wdata[7:0];
                            mem_wr_d = 1'b1;
                        end
                    end else begin
                        state_d = READ;
                        data_d  = '0;
                    end
                end
            end
            // RAM returns the byte one cycle after its address, so byte k lands at count k+1.
            READ: begin
                if (clear && CLEAR_MASK[owner_q]) begin
                    state_d = IDLE;
                    mem_a_d = '0;
                end else begin
                    if (cnt_q != 3'd0)
                        data_d[{rd_k, 3'b000} +: 8] = mem_din;
                    if (cnt_q == nbytes_q) begin
                        state_d         = IDLE;
                        resp_d[owner_q] = 1'b1;
                        resp_rd_d       = 1'b1;
                    end else begin
                        cnt_d   = next_k;
                        mem_a_d = (next_k == nbytes_q) ? '0 : next_a;
                    end
                end
            end
            WRITE: begin
                if (next_k == nbytes_q) begin
                    state_d         = IDLE;
                    mem_a_d         = '0;
                    resp_d[owner_q] = 1'b1;
                    resp_rd_d       = 1'b0;
                end else if (is_io(next_a) && io_buffer_full) begin
                    state_d = IO_WAIT;
                    cnt_d   = next_k;
                    mem_a_d = '0;
                end else begin
                    cnt_d    = next_k;
                    mem_a_d  = next_a;
                    dout_d   = wdata_q[{next_k[1:0], 3'b000} +: 8];
                    mem_wr_d = 1'b1;
                end
            end
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d  = WRITE;
                    mem_a_d  = addr_q + {29'd0, cnt_q};
                    dout_d   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem_wr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nbytes_q  <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            mem_a_q   <= '0;
            dout_q    <= '0;
            mem_wr_q  <= 1'b0;
            resp_q    <= '0;
            resp_rd_q <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nbytes_q  <= nbytes_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            mem_a_q   <= mem_a_d;
            dout_q    <= dout_d;
            mem_wr_q  <= mem_wr_d;
            resp_q    <= resp_d;
            resp_rd_q <= resp_rd_d;
`ifdef MEM_PORT_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // Gating mem_wr with rdy keeps a frozen byte from being written more than once.
    assign mem_wr     = mem_wr_q & rdy;
    assign mem_a      = mem_a_q;
    assign mem_dout   = dout_q;
    assign resp_data  = data_q;
    assign resp_ready = resp_q & ~((clear && resp_rd_q) ? CLEAR_MASK : '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for IO back-pressure, clear, rdy stall, reset and arbitration.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, clear, io_buffer_full;
    logic [1:0]  req_valid, req_wr;
    logic [3:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:262143];
    int          wr_total = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        int          ch;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_CH(2), .CLEAR_MASK(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Synchronous byte RAM: read data follows the address by one cycle.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_total <= wr_total + 1;
        end
        if (rst) begin
            ram[18'h00100] <= 8'h11;
            ram[18'h00101] <= 8'h22;
            ram[18'h00102] <= 8'h33;
            ram[18'h00103] <= 8'h44;
            ram[18'h3fffe] <= 8'ha1;
            ram[18'h3ffff] <= 8'ha2;
            ram[18'h00000] <= 8'ha3;
            ram[18'h00001] <= 8'ha4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input int c, input bit wr, input int ch,
                               input int cf, input int ct, input int rf, input int rt);
        clear = (c >= cf && c <= ct);
        rdy   = !(c >= rf && c <= rt);
        if (clear && !wr) req_valid[ch] = 1'b0;
        if (!rdy) begin
            #1;
            check($sformatf("mem_wr gated c%0d", c), {31'd0, mem_wr}, 32'd0);
        end
    endtask

    // lat = edges from accept to the visible pulse; 0 means no pulse within the budget.
    task automatic do_txn(input int ch, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int cf, input int ct, input int rf, input int rt,
                          output int lat, output logic [31:0] data);
        req_wr[ch]            = wr;
        req_size[2*ch +: 2]   = size;
        req_addr[32*ch +: 32] = addr;
        req_wdata[32*ch +: 32] = wdata;
        req_valid[ch]         = 1'b1;
        lat  = 0;
        data = '0;
        @(posedge clk); #1;
        drive_cycle(0, wr, ch, cf, ct, rf, rt);
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (resp_ready[ch]) begin
                lat  = c;
                data = resp_data;
                req_valid[ch] = 1'b0;
            end else begin
                drive_cycle(c, wr, ch, cf, ct, rf, rt);
            end
        end
        req_valid[ch] = 1'b0;
        clear = 1'b0;
        rdy   = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          w0;
        int          nb;
        int          got;
        logic [31:0] data;
        logic [1:0]  pulses[4];
        logic [1:0]  exp_p;

        vecs[0]  = '{0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211, 5};
        vecs[1]  = '{0, 1'b1, 2'd1, 32'h0000_0202, 32'h0000_beef, 32'h0,         2};
        vecs[2]  = '{1, 1'b0, 2'd1, 32'h0000_0202, 32'h0,         32'h0000_beef, 3};
        vecs[3]  = '{1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0000_0011, 2};
        vecs[4]  = '{1, 1'b0, 2'd1, 32'h0000_0101, 32'h0,         32'h0000_3322, 3};
        vecs[5]  = '{0, 1'b1, 2'd2, 32'h0000_01fe, 32'hdead_beef, 32'h0,         4};
        vecs[6]  = '{1, 1'b0, 2'd2, 32'h0000_01fe, 32'h0,         32'hdead_beef, 5};
        vecs[7]  = '{0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'h4433_2211, 5};
        vecs[8]  = '{0, 1'b0, 2'd0, 32'h0000_0103, 32'h0,         32'h0000_0044, 2};
        vecs[9]  = '{1, 1'b0, 2'd2, 32'hffff_fffe, 32'h0,         32'ha4a3_a2a1, 5};
        vecs[10] = '{0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005a, 32'h0,         1};
        vecs[11] = '{1, 1'b0, 2'd0, 32'h0003_0000, 32'h0,         32'h0000_005a, 2};

        // Clock / reset
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset resp_ready", {30'd0, resp_ready}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'd0);

        // Table of single transactions
        for (int i = 0; i < 12; i++) begin
            w0 = wr_total;
            do_txn(vecs[i].ch, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                   99, 0, 99, 0, lat, data);
            nb = (vecs[i].size == 2'd0) ? 1 : (vecs[i].size == 2'd1) ? 2 : 4;
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].wr)
                check($sformatf("vec%0d bytes written", i), wr_total - w0, nb);
            else begin
                check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
                check($sformatf("vec%0d no write", i), wr_total - w0, 0);
            end
        end

        // IO write held off by a full UART buffer for three edges
        io_buffer_full = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
        join_none
        w0 = wr_total;
        do_txn(0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 99, 0, 99, 0, lat, data);
        check("io latency", lat, 4);
        check("io bytes written", wr_total - w0, 1);
        check("io ram byte", {24'd0, ram[18'h30000]}, 32'h41);

        // Clear during a channel-1 word read aborts it silently
        do_txn(1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 99, 0, lat, data);
        check("clear read no pulse", lat, 0);
        do_txn(1, 1'b0, 2'd0, 32'h0000_0101, 32'h0, 99, 0, 99, 0, lat, data);
        check("after abort latency", lat, 2);
        check("after abort data", data, 32'h22);

        // Clear during a word write: write completes and pulses
        w0 = wr_total;
        do_txn(0, 1'b1, 2'd2, 32'h0000_0400, 32'hcafe_babe, 1, 10, 99, 0, lat, data);
        check("clear write latency", lat, 4);
        check("clear write bytes", wr_total - w0, 4);
        do_txn(1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 99, 0, 99, 0, lat, data);
        check("clear write readback", data, 32'hcafe_babe);

        // rdy low for two cycles in the middle of a word write
        w0 = wr_total;
        do_txn(0, 1'b1, 2'd2, 32'h0000_0600, 32'h1122_3344, 99, 0, 2, 3, lat, data);
        check("rdy stall latency", lat, 6);
        check("rdy stall bytes", wr_total - w0, 4);
        do_txn(1, 1'b0, 2'd2, 32'h0000_0600, 32'h0, 99, 0, 99, 0, lat, data);
        check("rdy stall readback", data, 32'h1122_3344);

        // Reset in the middle of a read returns everything to the reset state
        req_wr[0] = 1'b0; req_size[1:0] = 2'd2; req_addr[31:0] = 32'h0000_0100;
        req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid read mem_a", mem_a, 32'h0000_0102);
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid reset mem_a", mem_a, 32'd0);
        check("mid reset resp_data", resp_data, 32'd0);

        // Both channels requesting word reads continuously
        req_wr = '0; req_size = 4'b1010;
        req_addr = {32'h0000_01fe, 32'h0000_0100};
        req_valid = 2'b11;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(posedge clk); #1;
            if (resp_ready != 2'b00) begin
                pulses[got] = resp_ready;
                if (got == 3) req_valid = '0;
                got++;
            end
        end
        req_valid = '0;
        check("arb pulse count", got, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_PORT_ARB_RR_EN
            exp_p = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_p = 2'b01;
`endif
            if (k < got) check($sformatf("arb grant %0d", k), {30'd0, pulses[k]}, {30'd0, exp_p});
        end
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
